// File: rtl/rr_select4_pkg.sv
// Shared types and constants for the four-way round-robin mux selector.
package rr_select4_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned SEL_W            = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Decode a mux select into the matching one-hot grant.
  function automatic logic [NUM_REQ-1:0] onehot(logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after last+1, wrapping.
module rr_pick4
  import rr_select4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   pick
);

  // Walk the rotated request vector; the first hit wins and is already un-rotated.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    any   = |req;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = last + SEL_W'(i + 1);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_select4.sv
// Round-robin arbiter driving a 4:1 mux select; grants are held until done,
// request drop, or the hold limit.
module rr_select4
  import rr_select4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_W-1:0]     control,
  output logic                 valid,
  output logic                 timeout
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   control_q, control_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [SEL_W-1:0]   ptr;
  logic               pick_any;
  logic [SEL_W-1:0]   pick;
  logic               hold_hit;
  logic               owner_req;
  logic               release_grant;

  // While busy the search starts after the current owner, since last takes control on release.
  always_comb begin
    ptr = (state_q == BUSY) ? control_q : last_q;
  end

  rr_pick4 u_pick (
    .req  (req),
    .last (ptr),
    .any  (pick_any),
    .pick (pick)
  );

  // Release conditions for the current owner.
  always_comb begin
    hold_hit      = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    owner_req     = req[control_q];
    release_grant = done || !owner_req || hold_hit;
  end

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    control_d  = control_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = onehot(pick);
          control_d  = pick;
          valid_d    = 1'b1;
          hold_cnt_d = CNT_W'(1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!release_grant) begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else begin
          last_d    = control_q;
          timeout_d = hold_hit && !done && owner_req;
          if (pick_any) begin
            // Back-to-back handover; no idle bubble between owners.
            grant_d    = onehot(pick);
            control_d  = pick;
            valid_d    = 1'b1;
            hold_cnt_d = CNT_W'(1);
          end else begin
            // control is left alone so the mux output does not glitch.
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      control_q  <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= '1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      control_q  <= control_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign control = control_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
  a_valid_grant   : assert property (@(posedge clk) valid_q == (|grant_q));
  a_grant_control : assert property (@(posedge clk) !valid_q || (grant_q == onehot(control_q)));

endmodule

// File: tb/tb_rr_select4.sv
// Directed bench for rr_select4: one instance with MAX_HOLD=3, one with the timeout disabled.
module tb_rr_select4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;

  logic [3:0] grant,  grant0;
  logic [1:0] control, control0;
  logic       valid,  valid0;
  logic       timeout, timeout0;

  int passed = 0;
  int total  = 0;

  rr_select4 #(
    .MAX_HOLD (3),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .control (control),
    .valid   (valid),
    .timeout (timeout)
  );

  rr_select4 #(
    .MAX_HOLD (0),
    .CNT_W    (2)
  ) dut0 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant0),
    .control (control0),
    .valid   (valid0),
    .timeout (timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare the full output bundle of the MAX_HOLD=3 instance.
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] c,
                         input logic v, input logic t);
    chk({tag, ".grant"},   {4'b0, grant},   {4'b0, g});
    chk({tag, ".control"}, {6'b0, control}, {6'b0, c});
    chk({tag, ".valid"},   {7'b0, valid},   {7'b0, v});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [5];
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset values.
    do_reset();
    chk_out("rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0);

    // req=0101: requester 0 first, then done hands over to 2 with no bubble.
    req = 4'b0101;
    tick();
    chk_out("t1_first", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_out("t1_handover", 4'b0100, 2'b10, 1'b1, 1'b0);
    // Owner drops request, nobody else pending: idle, control kept.
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk_out("t5_drop", 4'b0000, 2'b10, 1'b0, 1'b0);

    // req=1111 with done every cycle: full rotation.
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11; seq[4] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      tick();
      oh = 4'b0001 << seq[i];
      chk_out($sformatf("t2_rot%0d", i), oh, seq[i], 1'b1, 1'b0);
    end
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk_out("t2_idle", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Sole requester held past MAX_HOLD=3: timeout pulse, immediate re-grant.
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("t3_hold%0d", i), 4'b0010, 2'b01, 1'b1, 1'b0);
    end
    tick();
    chk_out("t3_timeout", 4'b0010, 2'b01, 1'b1, 1'b1);
    chk("t3_nohold_timeout", {7'b0, timeout0}, 8'h00);
    chk("t3_nohold_grant",   {4'b0, grant0},   8'h02);
    tick();
    chk_out("t3_after", 4'b0010, 2'b01, 1'b1, 1'b0);
    tick();
    chk_out("t3_restart2", 4'b0010, 2'b01, 1'b1, 1'b0);
    tick();
    chk_out("t3_timeout2", 4'b0010, 2'b01, 1'b1, 1'b1);
    // Timeout-disabled instance keeps the grant despite the saturated counter.
    for (int i = 0; i < 6; i++) tick();
    chk("t3_nohold_long_grant",   {4'b0, grant0},   8'h02);
    chk("t3_nohold_long_timeout", {7'b0, timeout0}, 8'h00);
    chk("t3_nohold_long_valid",   {7'b0, valid0},   8'h01);

    // Two requesters held: timeouts alternate ownership fairly.
    do_reset();
    req = 4'b1010;
    tick();
    chk_out("t4_g1", 4'b0010, 2'b01, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("t4_g1_end", 4'b0010, 2'b01, 1'b1, 1'b0);
    tick();
    chk_out("t4_g3", 4'b1000, 2'b11, 1'b1, 1'b1);
    tick();
    chk_out("t4_g3_hold", 4'b1000, 2'b11, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("t4_back", 4'b0010, 2'b01, 1'b1, 1'b1);

    // Reset asserted mid-grant: outputs return to reset values without a timeout pulse.
    do_reset();
    req = 4'b1000;
    tick();
    chk_out("t6_grant", 4'b1000, 2'b11, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk_out("t6_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("t6_regrant", 4'b1000, 2'b11, 1'b1, 1'b0);

    // New request arriving while busy is served at the next release.
    req = 4'b1001;
    tick();
    chk_out("t7_wait", 4'b1000, 2'b11, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_out("t7_served", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_select4.md
Name: rr_select4

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 data multiplexer.
- Arbitrates four requesters and drives the mux's 2-bit control, plus a one-hot grant and a valid flag.
- Each grant is held until the owner signals done, drops its request, or a hold timeout expires.
- The selected source is therefore stable at the mux output for the whole transfer.

Parameters:
- MAX_HOLD, default 8: maximum cycles one grant may last; 0 disables the timeout.
- CNT_W, default 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  request vector, bit i = requester i
- done  input  1  current owner releases the grant; sampled only while valid=1
- grant  output  4  one-hot grant, all zero when idle
- control  output  2  mux select (00=A, 01=B, 10=C, 11=D), registered
- valid  output  1  a grant is active and control is meaningful
- timeout  output  1  one-cycle pulse, asserted on the cycle after a grant is revoked by MAX_HOLD

Behaviour:
- Single clock domain. Reset is synchronous and active-high; no asynchronous reset anywhere.
- Reset values: state=IDLE, grant=0000, control=00, valid=0, timeout=0, last=11, hold_cnt=0.
  - last=11 makes requester 0 the highest priority after reset.
- reset=1 mid-grant: same values on the next edge. The grant is dropped without a timeout pulse.
- States: IDLE and BUSY.
- Pick function: search req starting at index (last+1) mod 4, wrapping through 3 back to 0 and finally last. The first set bit wins.
- IDLE:
  - If req != 0, on the edge: grant = onehot(pick), control = pick, valid=1, hold_cnt=1, state=BUSY.
  - If req == 0, remain IDLE.
  - done is ignored in IDLE.
  - Latency is exactly one cycle from req sampled to grant visible.
- BUSY: release condition R = done OR !req[control] OR (MAX_HOLD != 0 AND hold_cnt == MAX_HOLD).
  - If R is false: hold all outputs and increment hold_cnt, saturating at 2^CNT_W-1.
  - If R is true: last <= control, and arbitration runs on the same edge with the pointer at control+1.
    - Another request pending (including the current owner re-requesting): grant it immediately with no idle bubble, hold_cnt=1, stay BUSY.
    - Nothing pending: grant=0000, valid=0, state=IDLE. control keeps its last value so the mux output does not glitch.
- timeout=1 for exactly one cycle when the release was caused solely by the hold limit (done=0 and req[control]=1).
- A timed-out requester that still requests is re-granted only after every other pending requester has been served (wrap-around fairness).
- Invariants checked by assertion:
  - grant is one-hot or zero.
  - valid == |grant.
  - When valid=1, grant == onehot(control).
- Requests arriving while another requester is granted are not lost; they are simply considered at the next release.
- Simultaneous done and a new req on the same edge: release and re-grant happen on that edge.
- MAX_HOLD=0: the hold_cnt compare is disabled and the counter saturates harmlessly.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=0 and BUSY=1
  - NUM_REQ=4 and SEL_W=2
  - the default MAX_HOLD
- One combinational sub-module, rr_pick4(req, last, any, pick): rotates req by last+1, priority-encodes, and rotates back.
- Both the IDLE and BUSY paths instantiate or share rr_pick4.
- Remaining RTL: the state register, the hold counter, and the output registers.

Test Plan:
- Reset then req=0101 held -> grant=0001, control=00, valid=1 one cycle after req. Then done=1 for one cycle -> next cycle grant=0100, control=10, no idle cycle.
- req=1111 with done pulsed every cycle -> control sequence 00,01,10,11,00, and each requester is granted exactly once per 4 grants.
- MAX_HOLD=3, req=0010 held, done=0 -> valid high for 3 cycles, timeout pulses once. Grant returns to 0010 next cycle (sole requester), hold_cnt restarts.
- MAX_HOLD=3, req=1010 held -> grant 0010 for 3 cycles, timeout pulse, grant 1000 for 3 cycles, timeout, back to 0010.
- Owner drops req with done=0 while req=0000 otherwise -> next cycle valid=0, grant=0000, control unchanged, timeout=0.
- reset=1 asserted mid-grant with req=1000 held -> next edge all outputs at reset values. First grant after reset deasserts is 1000, with control=11 one cycle later.
